// File: rtl/alu_rs_scheduler_if.sv
// Bundle of dispatch, CDB and ALU-issue signals around the ALU reservation station.
// The station is the slave; the dispatcher/CDB/ALU environment is the master.
interface alu_rs_scheduler_if #(
  parameter int IQ_ADDR_W = 5,
  parameter int CALC_W    = 4,
  parameter int WORD_W    = 32
);
  logic                 rdy;
  logic                 update_stat;
  logic                 clear_flag_in;

  logic                 dsp_enable_in;
  logic [CALC_W-1:0]    dsp_calc_code_in;
  logic                 dsp_lhs_ready_in;
  logic [WORD_W-1:0]    dsp_lhs_in;
  logic [IQ_ADDR_W-1:0] dsp_lhs_tag_in;
  logic                 dsp_rhs_ready_in;
  logic [WORD_W-1:0]    dsp_rhs_in;
  logic [IQ_ADDR_W-1:0] dsp_rhs_tag_in;
  logic [IQ_ADDR_W-1:0] dsp_pos_in_iq_in;
  logic                 rs_full_out;

  logic                 cdb_enable_in;
  logic [IQ_ADDR_W-1:0] cdb_tag_in;
  logic [WORD_W-1:0]    cdb_value_in;

  logic                 alu_full_in;
  logic                 alu_calc_enable_out;
  logic [CALC_W-1:0]    alu_calc_code_out;
  logic [WORD_W-1:0]    alu_lhs_out;
  logic [WORD_W-1:0]    alu_rhs_out;
  logic [IQ_ADDR_W-1:0] alu_pos_in_iq_out;

  modport slave (
    input  rdy, update_stat, clear_flag_in,
    input  dsp_enable_in, dsp_calc_code_in, dsp_lhs_ready_in, dsp_lhs_in, dsp_lhs_tag_in,
    input  dsp_rhs_ready_in, dsp_rhs_in, dsp_rhs_tag_in, dsp_pos_in_iq_in,
    output rs_full_out,
    input  cdb_enable_in, cdb_tag_in, cdb_value_in,
    input  alu_full_in,
    output alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
  );

  modport master (
    output rdy, update_stat, clear_flag_in,
    output dsp_enable_in, dsp_calc_code_in, dsp_lhs_ready_in, dsp_lhs_in, dsp_lhs_tag_in,
    output dsp_rhs_ready_in, dsp_rhs_in, dsp_rhs_tag_in, dsp_pos_in_iq_in,
    input  rs_full_out,
    output cdb_enable_in, cdb_tag_in, cdb_value_in,
    output alu_full_in,
    input  alu_calc_enable_out, alu_calc_code_out, alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// Reservation station for the single integer ALU: buffers dispatched ops, wakes operands
// from the CDB and issues the lowest-index fully-ready entry on the update_stat=0 phase.
module alu_rs_scheduler #(
  parameter int RS_SIZE   = 8,
  parameter int IQ_ADDR_W = 5,
  parameter int CALC_W    = 4,
  parameter int WORD_W    = 32
) (
  input logic               clk,
  input logic               rst,
  alu_rs_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [CALC_W-1:0]    code;
    logic [WORD_W-1:0]    lhs;
    logic                 lhs_rdy;
    logic [IQ_ADDR_W-1:0] lhs_tag;
    logic [WORD_W-1:0]    rhs;
    logic                 rhs_rdy;
    logic [IQ_ADDR_W-1:0] rhs_tag;
    logic [IQ_ADDR_W-1:0] pos;
  } entry_t;

  entry_t             entries [RS_SIZE];
  logic [RS_SIZE-1:0] valid;
  logic [RS_SIZE-1:0] ready;
  logic               en;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic               full;
  logic               lhs_hit;
  logic               rhs_hit;
  entry_t             incoming;

  assign full            = &valid;
  assign bus.rs_full_out = full;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = valid[i] & entries[i].lhs_rdy & entries[i].rhs_rdy;
    end
  end

  // Scanning from the top down leaves the lowest matching index in each result.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
      end
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // A dispatched operand that is being broadcast on this very edge enters already ready.
  always_comb begin
    lhs_hit          = bus.cdb_enable_in && !bus.dsp_lhs_ready_in && (bus.dsp_lhs_tag_in == bus.cdb_tag_in);
    rhs_hit          = bus.cdb_enable_in && !bus.dsp_rhs_ready_in && (bus.dsp_rhs_tag_in == bus.cdb_tag_in);
    incoming.code    = bus.dsp_calc_code_in;
    incoming.lhs     = lhs_hit ? bus.cdb_value_in : bus.dsp_lhs_in;
    incoming.lhs_rdy = bus.dsp_lhs_ready_in | lhs_hit;
    incoming.lhs_tag = bus.dsp_lhs_tag_in;
    incoming.rhs     = rhs_hit ? bus.cdb_value_in : bus.dsp_rhs_in;
    incoming.rhs_rdy = bus.dsp_rhs_ready_in | rhs_hit;
    incoming.rhs_tag = bus.dsp_rhs_tag_in;
    incoming.pos     = bus.dsp_pos_in_iq_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en                      <= 1'b0;
      valid                   <= '0;
      bus.alu_calc_enable_out <= 1'b0;
      bus.alu_calc_code_out   <= '0;
      bus.alu_lhs_out         <= '0;
      bus.alu_rhs_out         <= '0;
      bus.alu_pos_in_iq_out   <= '0;
    end else begin
      en <= bus.rdy;
      if (en) begin
        if (bus.clear_flag_in) begin
          valid                   <= '0;
          bus.alu_calc_enable_out <= 1'b0;
          bus.alu_calc_code_out   <= '0;
          bus.alu_lhs_out         <= '0;
          bus.alu_rhs_out         <= '0;
          bus.alu_pos_in_iq_out   <= '0;
        end else if (bus.update_stat) begin
          bus.alu_calc_enable_out <= 1'b0;
          for (int i = 0; i < RS_SIZE; i++) begin
            if (valid[i] && bus.cdb_enable_in) begin
              if (!entries[i].lhs_rdy && entries[i].lhs_tag == bus.cdb_tag_in) begin
                entries[i].lhs     <= bus.cdb_value_in;
                entries[i].lhs_rdy <= 1'b1;
              end
              if (!entries[i].rhs_rdy && entries[i].rhs_tag == bus.cdb_tag_in) begin
                entries[i].rhs     <= bus.cdb_value_in;
                entries[i].rhs_rdy <= 1'b1;
              end
            end
          end
          if (bus.dsp_enable_in && !full) begin
            entries[free_idx] <= incoming;
            valid[free_idx]   <= 1'b1;
          end
        end else if (!bus.alu_full_in && sel_found) begin
          bus.alu_calc_enable_out <= 1'b1;
          bus.alu_calc_code_out   <= entries[sel_idx].code;
          bus.alu_lhs_out         <= entries[sel_idx].lhs;
          bus.alu_rhs_out         <= entries[sel_idx].rhs;
          bus.alu_pos_in_iq_out   <= entries[sel_idx].pos;
          valid[sel_idx]          <= 1'b0;
        end else begin
          bus.alu_calc_enable_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: a slot-array reference model predicts issues,
// a monitor compares every post-edge output against it.
module tb_alu_rs_scheduler;
  localparam int RS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rs_scheduler_if #(.IQ_ADDR_W(5), .CALC_W(4), .WORD_W(32)) io ();

  alu_rs_scheduler #(.RS_SIZE(RS), .IQ_ADDR_W(5), .CALC_W(4), .WORD_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  typedef struct {
    bit          v;
    logic [3:0]  code;
    logic [31:0] l;
    bit          lr;
    logic [4:0]  lt;
    logic [31:0] r;
    bit          rr;
    logic [4:0]  rt;
    logic [4:0]  pos;
  } slot_t;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] l;
    logic [31:0] r;
    logic [4:0]  pos;
  } iss_t;

  slot_t m [RS];
  iss_t  sb [$];
  iss_t  cur;
  bit    mEn, expEnable, expFull, monOn;
  int    checks = 0;
  int    passes = 0;

  function automatic bit modelFull();
    bit f = 1'b1;
    foreach (m[i]) f &= m[i].v;
    return f;
  endfunction

  // Reference: an op occupies the lowest empty slot; a broadcast then refreshes every
  // live slot (the newcomer included), which yields the same-edge bypass naturally.
  task automatic modelStep();
    bit wasFull, found;
    if (rst) begin
      foreach (m[i]) m[i].v = 1'b0;
      mEn = 1'b0; expEnable = 1'b0; expFull = 1'b0;
      sb.delete();
      return;
    end
    if (mEn) begin
      if (io.clear_flag_in) begin
        foreach (m[i]) m[i].v = 1'b0;
        expEnable = 1'b0;
      end else if (io.update_stat) begin
        expEnable = 1'b0;
        wasFull = modelFull();
        found = 1'b0;
        if (io.dsp_enable_in && !wasFull) begin
          for (int i = 0; i < RS; i++) begin
            if (!found && !m[i].v) begin
              found = 1'b1;
              m[i] = '{1'b1, io.dsp_calc_code_in, io.dsp_lhs_in, io.dsp_lhs_ready_in, io.dsp_lhs_tag_in,
                       io.dsp_rhs_in, io.dsp_rhs_ready_in, io.dsp_rhs_tag_in, io.dsp_pos_in_iq_in};
            end
          end
        end
        if (io.cdb_enable_in) begin
          foreach (m[i]) begin
            if (m[i].v && !m[i].lr && m[i].lt == io.cdb_tag_in) begin m[i].l = io.cdb_value_in; m[i].lr = 1'b1; end
            if (m[i].v && !m[i].rr && m[i].rt == io.cdb_tag_in) begin m[i].r = io.cdb_value_in; m[i].rr = 1'b1; end
          end
        end
      end else begin
        expEnable = 1'b0;
        found = 1'b0;
        if (!io.alu_full_in) begin
          for (int i = 0; i < RS; i++) begin
            if (!found && m[i].v && m[i].lr && m[i].rr) begin
              found = 1'b1;
              sb.push_back('{m[i].code, m[i].l, m[i].r, m[i].pos});
              m[i].v = 1'b0;
              expEnable = 1'b1;
            end
          end
        end
      end
    end
    expFull = modelFull();
    mEn = io.rdy;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    cur = '{4'd0, 32'd0, 32'd0, 5'd0};
    forever begin
      @(posedge clk);
      #1;
      if (monOn) begin
        checks++;
        if (io.alu_calc_enable_out === expEnable) passes++;
        else $display("[TB] FAIL issue_valid got %0b want %0b at %0t", io.alu_calc_enable_out, expEnable, $time);
        checks++;
        if (io.rs_full_out === expFull) passes++;
        else $display("[TB] FAIL rs_full got %0b want %0b at %0t", io.rs_full_out, expFull, $time);
        if (io.alu_calc_enable_out === 1'b1) begin
          if (sb.size() > 0) cur = sb.pop_front();
          checks++;
          if (io.alu_calc_code_out === cur.code && io.alu_lhs_out === cur.l &&
              io.alu_rhs_out === cur.r && io.alu_pos_in_iq_out === cur.pos) passes++;
          else $display("[TB] FAIL issue_payload got code=%0h lhs=%h rhs=%h pos=%0d want code=%0h lhs=%h rhs=%h pos=%0d at %0t",
                        io.alu_calc_code_out, io.alu_lhs_out, io.alu_rhs_out, io.alu_pos_in_iq_out,
                        cur.code, cur.l, cur.r, cur.pos, $time);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input bit upd);
    io.update_stat = upd;
    modelStep();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    io.dsp_enable_in = 1'b0;
    io.cdb_enable_in = 1'b0;
    io.clear_flag_in = 1'b0;
  endtask

  task automatic pairStep();
    applyStimulus(1'b1);
    idleInputs();
    applyStimulus(1'b0);
  endtask

  task automatic setDispatch(input logic [3:0] code, input bit lr, input logic [31:0] l, input logic [4:0] lt,
                             input bit rr, input logic [31:0] r, input logic [4:0] rt, input logic [4:0] pos);
    io.dsp_enable_in    = 1'b1;
    io.dsp_calc_code_in = code;
    io.dsp_lhs_ready_in = lr;
    io.dsp_lhs_in       = l;
    io.dsp_lhs_tag_in   = lt;
    io.dsp_rhs_ready_in = rr;
    io.dsp_rhs_in       = r;
    io.dsp_rhs_tag_in   = rt;
    io.dsp_pos_in_iq_in = pos;
  endtask

  task automatic setCdb(input logic [4:0] tag, input logic [31:0] val);
    io.cdb_enable_in = 1'b1;
    io.cdb_tag_in    = tag;
    io.cdb_value_in  = val;
  endtask

  initial begin
    rst = 1'b1;
    io.rdy = 1'b1;
    io.update_stat = 1'b0;
    io.alu_full_in = 1'b0;
    setDispatch(4'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0);
    setCdb(5'd0, 32'd0);
    idleInputs();
    @(negedge clk);
    monOn = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    rst = 1'b0;
    checkOutput("reset_enable", {31'd0, io.alu_calc_enable_out}, 32'd0);
    checkOutput("reset_lhs", io.alu_lhs_out, 32'd0);
    checkOutput("reset_rhs", io.alu_rhs_out, 32'd0);
    checkOutput("reset_pos", {27'd0, io.alu_pos_in_iq_out}, 32'd0);
    checkOutput("reset_full", {31'd0, io.rs_full_out}, 32'd0);
    pairStep();

    // Ready dispatch, then wakeup, then same-edge bypass.
    setDispatch(4'd0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 5'd3);
    pairStep();
    pairStep();
    setDispatch(4'd1, 1'b0, 32'd0, 5'd9, 1'b1, 32'd11, 5'd0, 5'd4);
    pairStep();
    setCdb(5'd9, 32'h100);
    pairStep();
    pairStep();
    setDispatch(4'd2, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd2, 5'd6);
    setCdb(5'd2, 32'hABCD);
    pairStep();
    pairStep();

    // Fill, drop, backpressure while entries 6 and 2 wake, then in-order release.
    for (int i = 0; i < RS; i++) begin
      setDispatch(4'(i), 1'b1, 32'(i + 100), 5'd0, 1'b0, 32'd0, 5'(10 + i), 5'(8 + i));
      pairStep();
    end
    checkOutput("fill_full", {31'd0, io.rs_full_out}, 32'd1);
    setDispatch(4'hF, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF, 5'd0, 5'd30);
    pairStep();
    io.alu_full_in = 1'b1;
    setCdb(5'd16, 32'h6666);
    pairStep();
    setCdb(5'd12, 32'h2222);
    pairStep();
    pairStep();
    checkOutput("backpressure_enable", {31'd0, io.alu_calc_enable_out}, 32'd0);
    io.alu_full_in = 1'b0;
    pairStep();
    checkOutput("first_release_pos", {27'd0, io.alu_pos_in_iq_out}, 32'd10);
    pairStep();
    foreach (m[i]) begin
      if (i != 2 && i != 6) begin
        setCdb(5'(10 + i), 32'(i * 4096));
        pairStep();
      end
    end
    for (int i = 0; i < 8; i++) pairStep();

    // Flush with three live entries and one issue on the ALU bus.
    io.alu_full_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setDispatch(4'(i + 3), 1'b1, 32'(i + 50), 5'd0, 1'b1, 32'(i + 60), 5'd0, 5'(20 + i));
      pairStep();
    end
    io.alu_full_in = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    io.clear_flag_in = 1'b1;
    applyStimulus(1'b1);
    idleInputs();
    checkOutput("flush_enable", {31'd0, io.alu_calc_enable_out}, 32'd0);
    checkOutput("flush_lhs", io.alu_lhs_out, 32'd0);
    checkOutput("flush_full", {31'd0, io.rs_full_out}, 32'd0);
    applyStimulus(1'b0);
    for (int i = 0; i < 3; i++) pairStep();

    // Freeze: an entry waits behind alu_full, then rdy drops while inputs toggle.
    io.alu_full_in = 1'b1;
    setDispatch(4'd7, 1'b1, 32'h77, 5'd0, 1'b1, 32'h88, 5'd0, 5'd25);
    pairStep();
    io.rdy = 1'b0;
    io.alu_full_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setDispatch(4'(i), 1'b1, 32'(i), 5'd0, 1'b1, 32'(i), 5'd0, 5'(i));
      setCdb(5'(i), 32'(i + 1));
      applyStimulus(1'(i % 2 == 0));
    end
    idleInputs();
    io.rdy = 1'b1;
    for (int i = 0; i < 3; i++) pairStep();

    // Randomized traffic with occasional flush, freeze and one mid-run reset.
    for (int n = 0; n < 600; n++) begin
      io.dsp_enable_in = 1'($urandom_range(0, 1));
      setDispatch(4'($urandom), 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)), 5'($urandom));
      io.dsp_enable_in = 1'($urandom_range(0, 1));
      setCdb(5'($urandom_range(0, 7)), $urandom);
      io.cdb_enable_in = ($urandom_range(0, 9) < 4);
      io.alu_full_in   = ($urandom_range(0, 3) == 0);
      io.clear_flag_in = ($urandom_range(0, 49) == 0);
      io.rdy           = ($urandom_range(0, 14) != 0);
      rst              = (n == 300);
      applyStimulus(1'(n % 2 == 0));
    end
    rst = 1'b0;
    idleInputs();
    io.rdy = 1'b1;
    io.alu_full_in = 1'b0;
    for (int i = 0; i < 12; i++) pairStep();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
